// File: rtl/sprite_blitter_if.sv
// Sprite blitter bus: draw request, sprite ROM read port and VGA pixel write port.
// The blitter takes the slave side; the controller/ROM/VGA environment takes the master side.
interface sprite_blitter_if #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned COLOR_W = 3
);
    logic               idrawEn;
    logic [8:0]         ix_pos;
    logic [7:0]         iy_pos;
    logic [2:0]         isel;
    logic [ADDR_W-1:0]  orom_addr;
    logic [COLOR_W-1:0] irom_data;
    logic [8:0]         ox;
    logic [7:0]         oy;
    logic [COLOR_W-1:0] ocolor_out;
    logic               owriteEn;
    logic               obusy;
    logic               oDoneSignal;

    modport slave (
        input  idrawEn, ix_pos, iy_pos, isel, irom_data,
        output orom_addr, ox, oy, ocolor_out, owriteEn, obusy, oDoneSignal
    );

    modport master (
        output idrawEn, ix_pos, iy_pos, isel, irom_data,
        input  orom_addr, ox, oy, ocolor_out, owriteEn, obusy, oDoneSignal
    );
endinterface

// File: rtl/sprite_blitter.sv
// Generic sprite-to-framebuffer copier: rasters one SPR_W x SPR_H image from the sprite ROM
// to the VGA write port at one pixel per clock, with colour-key transparency and screen clipping.
module sprite_blitter #(
    parameter int unsigned SPR_W      = 16,
    parameter int unsigned SPR_H      = 52,
    parameter int unsigned NUM_SPR    = 7,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned COLOR_W    = 3,
    parameter int unsigned ROM_LAT    = 1,
    parameter int unsigned TRANSP_EN  = 0,
    parameter logic [COLOR_W-1:0] TRANSP_CLR = '0,
    parameter int unsigned SCR_W      = 320,
    parameter int unsigned SCR_H      = 240
) (
    input  logic           iCLOCK_50,
    input  logic           iresetn,
    sprite_blitter_if.slave bus
);

    localparam int unsigned PIX = SPR_W * SPR_H;
    localparam int unsigned XW  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned YW  = (SPR_H > 1) ? $clog2(SPR_H) + 1 : 1;

    typedef enum logic [2:0] {IDLE, LATCH, RUN, FLUSH, DONE} state_t;

    state_t state, state_nx;

    logic [XW-1:0]     x_cnt;
    logic [YW-1:0]     y_cnt;
    logic [8:0]        x_org;
    logic [7:0]        y_org;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        fl_cnt;
    logic [2:0]        sel_eff;
    logic [ADDR_W-1:0] base;
    logic              last_x;
    logic              last_pix;

    assign last_x   = (x_cnt == XW'(SPR_W - 1));
    assign last_pix = last_x && (y_cnt == YW'(SPR_H - 1));
    assign sel_eff  = (32'(bus.isel) < NUM_SPR) ? bus.isel : '0;
    assign base     = ADDR_W'(32'(sel_eff) * PIX);

    always_ff @(posedge iCLOCK_50) begin
        if (!iresetn) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        bus.obusy = 1'b1;
        case (state)
            IDLE: begin
                bus.obusy = 1'b0;
                if (bus.idrawEn) state_nx = LATCH;
            end
            LATCH: state_nx = RUN;
            RUN:   if (last_pix) state_nx = FLUSH;
            FLUSH: if (fl_cnt == 3'(ROM_LAT - 1)) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Raster order makes the ROM address a plain incrementer from the sprite base.
    always_ff @(posedge iCLOCK_50) begin
        if (!iresetn) begin
            x_cnt  <= '0;
            y_cnt  <= '0;
            x_org  <= '0;
            y_org  <= '0;
            addr_q <= '0;
            fl_cnt <= '0;
        end else begin
            case (state)
                LATCH: begin
                    x_org  <= bus.ix_pos;
                    y_org  <= bus.iy_pos;
                    addr_q <= base;
                    x_cnt  <= '0;
                    y_cnt  <= '0;
                    fl_cnt <= '0;
                end
                RUN: begin
                    if (!last_pix) addr_q <= addr_q + ADDR_W'(1);
                    if (last_x) begin
                        x_cnt <= '0;
                        y_cnt <= y_cnt + YW'(1);
                    end else begin
                        x_cnt <= x_cnt + XW'(1);
                    end
                end
                FLUSH: fl_cnt <= fl_cnt + 3'd1;
                default: ;
            endcase
        end
    end

    assign bus.orom_addr = addr_q;

    logic       issue_v;
    logic [9:0] issue_x;
    logic [8:0] issue_y;

    assign issue_v = (state == RUN);
    assign issue_x = 10'(x_org) + 10'(x_cnt);
    assign issue_y = 9'(y_org) + 9'(y_cnt);

    logic       pv [ROM_LAT];
    logic [9:0] px [ROM_LAT];
    logic [8:0] py [ROM_LAT];

    always_ff @(posedge iCLOCK_50) begin
        if (!iresetn) begin
            for (int unsigned i = 0; i < ROM_LAT; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= issue_v;
            for (int unsigned i = 1; i < ROM_LAT; i++) pv[i] <= pv[i-1];
        end
    end

    always_ff @(posedge iCLOCK_50) begin
        px[0] <= issue_x;
        py[0] <= issue_y;
        for (int unsigned i = 1; i < ROM_LAT; i++) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
        end
    end

    logic tail_v, keyed, clipped, do_write;

    assign tail_v   = pv[ROM_LAT-1];
    assign keyed    = (TRANSP_EN != 0) && (bus.irom_data == TRANSP_CLR);
    assign clipped  = (px[ROM_LAT-1] >= 10'(SCR_W)) || (py[ROM_LAT-1] >= 9'(SCR_H));
    assign do_write = tail_v && !keyed && !clipped;

    // Suppressed pixels still occupy their slot, so draw timing never depends on content.
    always_ff @(posedge iCLOCK_50) begin
        if (!iresetn) begin
            bus.owriteEn    <= 1'b0;
            bus.oDoneSignal <= 1'b0;
            bus.ox          <= '0;
            bus.oy          <= '0;
            bus.ocolor_out  <= '0;
        end else begin
            bus.owriteEn    <= do_write;
            bus.oDoneSignal <= (state == DONE);
            if (do_write) begin
                bus.ox         <= px[ROM_LAT-1][8:0];
                bus.oy         <= py[ROM_LAT-1][7:0];
                bus.ocolor_out <= bus.irom_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: three 4x3 instances (ROM_LAT 1, ROM_LAT 3, colour key on)
// driven by directed draws; a negedge monitor pops expected pixels and done pulses with cycle stamps.
module tb_sprite_blitter;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sprite_blitter_if #(.ADDR_W(12), .COLOR_W(3)) if_a ();
    sprite_blitter_if #(.ADDR_W(12), .COLOR_W(3)) if_b ();
    sprite_blitter_if #(.ADDR_W(12), .COLOR_W(3)) if_c ();

    sprite_blitter #(.SPR_W(4), .SPR_H(3), .NUM_SPR(7), .ADDR_W(12), .COLOR_W(3), .ROM_LAT(1),
                     .TRANSP_EN(0), .TRANSP_CLR(3'b000), .SCR_W(320), .SCR_H(240))
        dut_a (.iCLOCK_50(clk), .iresetn(rstn), .bus(if_a));
    sprite_blitter #(.SPR_W(4), .SPR_H(3), .NUM_SPR(7), .ADDR_W(12), .COLOR_W(3), .ROM_LAT(3),
                     .TRANSP_EN(0), .TRANSP_CLR(3'b000), .SCR_W(320), .SCR_H(240))
        dut_b (.iCLOCK_50(clk), .iresetn(rstn), .bus(if_b));
    sprite_blitter #(.SPR_W(4), .SPR_H(3), .NUM_SPR(7), .ADDR_W(12), .COLOR_W(3), .ROM_LAT(1),
                     .TRANSP_EN(1), .TRANSP_CLR(3'b000), .SCR_W(320), .SCR_H(240))
        dut_c (.iCLOCK_50(clk), .iresetn(rstn), .bus(if_c));

    logic       draw_en [3];
    logic [8:0] xp;
    logic [7:0] yp;
    logic [2:0] sp;

    assign if_a.idrawEn = draw_en[0];
    assign if_b.idrawEn = draw_en[1];
    assign if_c.idrawEn = draw_en[2];
    assign if_a.ix_pos = xp; assign if_a.iy_pos = yp; assign if_a.isel = sp;
    assign if_b.ix_pos = xp; assign if_b.iy_pos = yp; assign if_b.isel = sp;
    assign if_c.ix_pos = xp; assign if_c.iy_pos = yp; assign if_c.isel = sp;

    // ROM image: colour = addr%7+1; the keyed instance has words 0 and 5 set to the key colour.
    function automatic logic [2:0] rom_val(int d, int a);
        if (d == 2 && (a == 0 || a == 5)) return 3'd0;
        return 3'((a % 7) + 1);
    endfunction

    logic [2:0] ra, rc;
    logic [2:0] rb [3];
    always @(posedge clk) begin
        ra    <= rom_val(0, int'(if_a.orom_addr));
        rb[0] <= rom_val(1, int'(if_b.orom_addr));
        rb[1] <= rb[0];
        rb[2] <= rb[1];
        rc    <= rom_val(2, int'(if_c.orom_addr));
    end
    assign if_a.irom_data = ra;
    assign if_b.irom_data = rb[2];
    assign if_c.irom_data = rc;

    logic        wr [3], dn [3], bz [3];
    logic [8:0]  oxv [3];
    logic [7:0]  oyv [3];
    logic [2:0]  cov [3];
    logic [11:0] adv [3];
    assign wr[0] = if_a.owriteEn; assign dn[0] = if_a.oDoneSignal; assign bz[0] = if_a.obusy;
    assign wr[1] = if_b.owriteEn; assign dn[1] = if_b.oDoneSignal; assign bz[1] = if_b.obusy;
    assign wr[2] = if_c.owriteEn; assign dn[2] = if_c.oDoneSignal; assign bz[2] = if_c.obusy;
    assign oxv[0] = if_a.ox; assign oyv[0] = if_a.oy; assign cov[0] = if_a.ocolor_out;
    assign oxv[1] = if_b.ox; assign oyv[1] = if_b.oy; assign cov[1] = if_b.ocolor_out;
    assign oxv[2] = if_c.ox; assign oyv[2] = if_c.oy; assign cov[2] = if_c.ocolor_out;
    assign adv[0] = if_a.orom_addr; assign adv[1] = if_b.orom_addr; assign adv[2] = if_c.orom_addr;

    typedef struct {int dut; int x; int y; int c; int t;} pix_t;
    typedef struct {int dut; int t;} done_t;

    pix_t  exp_q[$];
    done_t done_q[$];
    int    checks = 0;
    int    failures = 0;
    int    wr_count = 0;
    pix_t  me;
    done_t md;

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (wr[d] === 1'b1) begin
                wr_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write actual dut=%0d (%0d,%0d) cyc=%0d required none",
                             d, oxv[d], oyv[d], cyc);
                end else begin
                    me = exp_q.pop_front();
                    if (me.dut != d || me.x != int'(oxv[d]) || me.y != int'(oyv[d]) ||
                        me.c != int'(cov[d]) || me.t != cyc) begin
                        failures++;
                        $display("FAIL pixel actual dut=%0d (%0d,%0d) c=%0d cyc=%0d required dut=%0d (%0d,%0d) c=%0d cyc=%0d",
                                 d, oxv[d], oyv[d], cov[d], cyc, me.dut, me.x, me.y, me.c, me.t);
                    end
                end
            end
            if (dn[d] === 1'b1) begin
                checks++;
                if (done_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done actual dut=%0d cyc=%0d required none", d, cyc);
                end else begin
                    md = done_q.pop_front();
                    if (md.dut != d || md.t != cyc) begin
                        failures++;
                        $display("FAIL done actual dut=%0d cyc=%0d required dut=%0d cyc=%0d",
                                 d, cyc, md.dut, md.t);
                    end
                end
            end
        end
    end

    task automatic push_draw(int d, int x, int y, int s, int lat, bit transp, int st,
                             int npush, bit push_done);
        int sel, a, px, py, c;
        sel = (s >= 7) ? 0 : s;
        for (int k = 0; k < 12 && k < npush; k++) begin
            px = x + k % 4;
            py = y + k / 4;
            a  = sel * 12 + k;
            c  = int'(rom_val(d, a));
            if (transp && c == 0) continue;
            if (px >= 320 || py >= 240) continue;
            exp_q.push_back('{d, px, py, c, st + lat + 2 + k});
        end
        if (push_done) done_q.push_back('{d, st + 2 + 12 + lat});
    endtask

    task automatic start_draw(int d, int x, int y, int s, int lat, bit transp, int npush, bit push_done);
        int st;
        @(negedge clk);
        xp = 9'(x); yp = 8'(y); sp = 3'(s);
        draw_en[d] = 1'b1;
        st = cyc + 1;
        push_draw(d, x, y, s, lat, transp, st, npush, push_done);
        @(negedge clk);
        draw_en[d] = 1'b0;
    endtask

    task automatic wait_quiet(string name, int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0 || bz[0] || bz[1] || bz[2]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s actual pending_pix=%0d pending_done=%0d required 0",
                     name, exp_q.size(), done_q.size());
            exp_q.delete();
            done_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_wr, n;
        rstn = 1'b0;
        for (int d = 0; d < 3; d++) draw_en[d] = 1'b0;
        xp = '0; yp = '0; sp = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_ctl%0d", d), int'({wr[d], bz[d], dn[d]}), 0);
            check($sformatf("reset_xy%0d", d), int'({oxv[d], oyv[d], cov[d]}), 0);
            check($sformatf("reset_addr%0d", d), int'(adv[d]), 0);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        start_draw(0, 5, 86, 0, 1, 1'b0, 12, 1'b1);
        wait_quiet("basic", 100);

        start_draw(0, 20, 30, 7, 1, 1'b0, 12, 1'b1);
        wait_quiet("sel_oob", 100);

        start_draw(1, 5, 86, 2, 3, 1'b0, 12, 1'b1);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("rom_addr_k%0d", k), int'(adv[1]), 24 + k);
        end
        wait_quiet("lat3", 100);

        start_draw(2, 5, 86, 0, 1, 1'b1, 12, 1'b1);
        wait_quiet("transp", 100);

        start_draw(0, 318, 238, 1, 1, 1'b0, 12, 1'b1);
        wait_quiet("clip", 100);

        // idrawEn held: one draw, then a restart on the first IDLE cycle after DONE.
        @(negedge clk);
        xp = 9'd40; yp = 8'd50; sp = 3'd3;
        draw_en[0] = 1'b1;
        n = cyc + 1;
        push_draw(0, 40, 50, 3, 1, 1'b0, n, 12, 1'b1);
        push_draw(0, 40, 50, 3, 1, 1'b0, n + 16, 12, 1'b1);
        repeat (17) @(negedge clk);
        draw_en[0] = 1'b0;
        repeat (5) @(negedge clk);
        xp = 9'd100; yp = 8'd10; sp = 3'd4;
        draw_en[0] = 1'b1;
        @(negedge clk);
        draw_en[0] = 1'b0;
        wait_quiet("held", 150);

        base_wr = wr_count;
        start_draw(0, 60, 70, 5, 1, 1'b0, 5, 1'b0);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            #1;
            if (wr_count >= base_wr + 5) break;
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL timeout_fifth_write actual writes=%0d required=%0d", wr_count - base_wr, 5);
        end
        rstn = 1'b0;
        @(negedge clk);
        check("rst_mid_write", int'(wr[0]), 0);
        check("rst_mid_busy", int'(bz[0]), 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_mid_pending", exp_q.size(), 0);
        start_draw(0, 60, 70, 5, 1, 1'b0, 12, 1'b1);
        wait_quiet("after_reset", 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
